// File: rtl/cache_id_sched_pkg.sv
// Shared types and defaults for the data_cache read-side ID scheduler.
package cache_sched_pkg;

  localparam int unsigned ID_W            = 8;
  localparam int unsigned NQ_DEFAULT      = 4;
  localparam int unsigned QDEPTH_DEFAULT  = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 4096;

  typedef enum logic {
    IDLE,
    WAIT
  } sched_state_t;

endpackage

// File: rtl/cache_id_sched_if.sv
// Descriptor enqueue, gate control and data_cache issue/end-of-packet signals.
interface cache_id_sched_if
  import cache_sched_pkg::*;
#(
  parameter int unsigned NQ = NQ_DEFAULT
) ();

  localparam int unsigned QW = (NQ > 1) ? $clog2(NQ) : 1;

  logic [ID_W-1:0] in_desc_ID;
  logic [QW-1:0]   in_desc_queue;
  logic            in_desc_wr;
  logic [NQ-1:0]   in_gate;
  logic            in_tx_ready;
  logic [ID_W-1:0] out_sched_ID;
  logic            out_sched_ID_wr;
  logic            in_cache_valid_wr;
  logic            in_cache_valid;
  logic [NQ-1:0]   out_q_empty;
  logic            out_drop;
  logic            out_timeout;
  logic            out_busy;

  modport master (
    input  in_desc_ID, in_desc_queue, in_desc_wr, in_gate, in_tx_ready,
    input  in_cache_valid_wr, in_cache_valid,
    output out_sched_ID, out_sched_ID_wr, out_q_empty, out_drop, out_timeout, out_busy
  );

  modport slave (
    output in_desc_ID, in_desc_queue, in_desc_wr, in_gate, in_tx_ready,
    output in_cache_valid_wr, in_cache_valid,
    input  out_sched_ID, out_sched_ID_wr, out_q_empty, out_drop, out_timeout, out_busy
  );

endinterface

// File: rtl/cache_id_sched_id_fifo.sv
// Synchronous ID FIFO; a push into a full FIFO is accepted only if it is popped the same cycle.
module id_fifo
  import cache_sched_pkg::*;
#(
  parameter int unsigned DEPTH = QDEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [ID_W-1:0] din,
  output logic [ID_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr, rd_ptr;
  logic [ID_W-1:0] mem [DEPTH];
  logic            wr_en, rd_en;

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
    dout  = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cache_id_sched.sv
// Strict-priority, gate-aware ID scheduler feeding data_cache one packet at a time.
module cache_id_sched
  import cache_sched_pkg::*;
#(
  parameter int unsigned NQ      = NQ_DEFAULT,
  parameter int unsigned QDEPTH  = QDEPTH_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  cache_id_sched_if.master   bus
);

  localparam int unsigned QW   = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  sched_state_t    state, state_n;
  logic [WD_W-1:0] wd, wd_n;
  logic [NQ-1:0]   push, pop, full, empty, elig;
  logic [ID_W-1:0] head [NQ];
  logic [QW-1:0]   sel;
  logic            sel_vld, issue, tmo_n, drop_n;
  logic            unused_cache_valid;

  // Packet-good flag does not influence scheduling.
  assign unused_cache_valid = bus.in_cache_valid;

  for (genvar q = 0; q < NQ; q++) begin : g_q
    assign push[q] = bus.in_desc_wr && (bus.in_desc_queue == QW'(q));

    id_fifo #(
      .DEPTH (QDEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[q]),
      .pop   (pop[q]),
      .din   (bus.in_desc_ID),
      .dout  (head[q]),
      .full  (full[q]),
      .empty (empty[q])
    );
  end

  always_comb begin
    elig    = ~empty & bus.in_gate & {NQ{bus.in_tx_ready}};
    sel     = '0;
    sel_vld = 1'b0;
    for (int unsigned q = 0; q < NQ; q++) begin
      if (elig[q]) begin
        sel     = QW'(q);
        sel_vld = 1'b1;
      end
    end
    drop_n = |(push & full & ~pop);
  end

  // The timeout pulse is shown while still in WAIT; the return to IDLE
  // happens on the following cycle so the pulse lands TIMEOUT cycles after issue.
  always_comb begin
    state_n = state;
    wd_n    = wd;
    pop     = '0;
    issue   = 1'b0;
    tmo_n   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          pop[sel] = 1'b1;
          issue    = 1'b1;
          wd_n     = '0;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (bus.in_cache_valid_wr || bus.out_timeout) begin
          state_n = IDLE;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          tmo_n = 1'b1;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      wd                  <= '0;
      bus.out_sched_ID    <= '0;
      bus.out_sched_ID_wr <= 1'b0;
      bus.out_drop        <= 1'b0;
      bus.out_timeout     <= 1'b0;
    end else begin
      state               <= state_n;
      wd                  <= wd_n;
      bus.out_sched_ID_wr <= issue;
      bus.out_drop        <= drop_n;
      bus.out_timeout     <= tmo_n;
      if (issue) bus.out_sched_ID <= head[sel];
    end
  end

  always_comb begin
    bus.out_q_empty = empty;
    bus.out_busy    = (state == WAIT);
  end

endmodule

// File: tb/tb_cache_id_sched.sv
// Scoreboard bench for cache_id_sched: expected IDs queued at stimulus, checked by a monitor.
module tb_cache_id_sched;
  import cache_sched_pkg::*;

  localparam int unsigned NQ      = 4;
  localparam int unsigned QDEPTH  = 32;
  localparam int unsigned TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_id_sched_if #(.NQ(NQ)) bus ();

  cache_id_sched #(
    .NQ      (NQ),
    .QDEPTH  (QDEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  int unsigned passed = 0, total = 0;
  int unsigned n_issue = 0, n_drop = 0, n_tmo = 0, last_drop = 0;
  logic [7:0]  exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every issue strobe is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_sched_ID_wr) begin
        n_issue++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_issue: got ID 0x%0h, expected no issue (cycle %0d)", bus.out_sched_ID, cyc);
        end else begin
          check("issue_id", bus.out_sched_ID, exp_q.pop_front());
        end
      end
      if (bus.out_drop) begin
        n_drop++;
        last_drop = cyc;
      end
      if (bus.out_timeout) n_tmo++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [7:0] id, input int unsigned q);
    bus.in_desc_ID    = id;
    bus.in_desc_queue = 2'(q);
    bus.in_desc_wr    = 1'b1;
    tick();
    bus.in_desc_wr    = 1'b0;
  endtask

  task automatic wait_issue(output int unsigned at, output logic busy);
    at   = 0;
    busy = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.out_sched_ID_wr) begin
        at   = cyc;
        busy = bus.out_busy;
        tick();
        return;
      end
    end
    total++;
    $display("FAIL issue_wait: got no issue, expected one within 64 cycles (cycle %0d)", cyc);
    tick();
  endtask

  task automatic complete(input logic good);
    bus.in_cache_valid_wr = 1'b1;
    bus.in_cache_valid    = good;
    tick();
    bus.in_cache_valid_wr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_id"},    bus.out_sched_ID,    32'h0);
    check({tag, "_wr"},    bus.out_sched_ID_wr, 32'h0);
    check({tag, "_empty"}, bus.out_q_empty,     32'hF);
    check({tag, "_drop"},  bus.out_drop,        32'h0);
    check({tag, "_tmo"},   bus.out_timeout,     32'h0);
    check({tag, "_busy"},  bus.out_busy,        32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    int unsigned t, at, a1, a2, c, n0, d0, tmo0, to_at;
    logic        b, found;

    bus.in_desc_ID        = '0;
    bus.in_desc_queue     = '0;
    bus.in_desc_wr        = 1'b0;
    bus.in_gate           = '0;
    bus.in_tx_ready       = 1'b0;
    bus.in_cache_valid_wr = 1'b0;
    bus.in_cache_valid    = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst             = 1'b0;
    bus.in_gate     = 4'hF;
    bus.in_tx_ready = 1'b1;

    // Basic issue: latency 2, busy with strobe, busy drops after end-of-packet
    exp_q.push_back(8'h05);
    t = cyc;
    enq(8'h05, 0);
    wait_issue(at, b);
    check("basic_latency", at, t + 2);
    check("busy_with_issue", b, 1'b1);
    tick();
    bus.in_cache_valid_wr = 1'b1;
    bus.in_cache_valid    = 1'b1;
    @(negedge clk);
    check("busy_during_eop", bus.out_busy, 1'b1);
    tick();
    bus.in_cache_valid_wr = 1'b0;
    @(negedge clk);
    check("busy_after_eop", bus.out_busy, 1'b0);
    tick();

    // Spurious end-of-packet in IDLE
    n0 = n_issue;
    complete(1'b1);
    repeat (3) tick();
    check("spurious_eop_no_issue", n_issue, n0);
    check("spurious_eop_busy", bus.out_busy, 1'b0);

    // Priority and gating
    bus.in_tx_ready = 1'b0;
    bus.in_gate     = 4'b1011;
    enq(8'h10, 0);
    enq(8'h20, 3);
    enq(8'h30, 2);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h10);
    n0 = n_issue;
    tick();
    bus.in_tx_ready = 1'b1;
    wait_issue(a1, b);
    c = cyc;
    complete(1'b1);
    wait_issue(a2, b);
    check("back_to_back", a2, c + 2);
    complete(1'b0);
    repeat (6) tick();
    check("gated_q2_held", n_issue, n0 + 2);
    check("gated_q2_nonempty", bus.out_q_empty, 4'b1011);
    exp_q.push_back(8'h30);
    bus.in_gate = 4'hF;
    wait_issue(at, b);
    complete(1'b1);
    repeat (2) tick();
    check("prio_drained", bus.out_q_empty, 4'hF);

    // Full queue: 33rd enqueue dropped, first 32 issued in order
    bus.in_tx_ready = 1'b0;
    d0 = n_drop;
    t  = 0;
    for (int i = 0; i < 33; i++) begin
      if (i < 32) exp_q.push_back(8'h40 + 8'(i));
      else t = cyc;
      enq(8'h40 + 8'(i), 1);
    end
    repeat (2) tick();
    check("full_drop_count", n_drop, d0 + 1);
    check("full_drop_cycle", last_drop, t + 1);
    bus.in_tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_issue(at, b);
      complete(1'b1);
    end
    repeat (2) tick();
    check("full_drained", bus.out_q_empty, 4'hF);
    check("full_scoreboard_empty", exp_q.size(), 0);

    // Timeout
    bus.in_tx_ready = 1'b0;
    exp_q.push_back(8'h7F);
    exp_q.push_back(8'h11);
    enq(8'h7F, 0);
    enq(8'h11, 0);
    tick();
    tmo0            = n_tmo;
    bus.in_tx_ready = 1'b1;
    wait_issue(at, b);
    found = 1'b0;
    to_at = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (bus.out_timeout) begin
        found = 1'b1;
        to_at = cyc;
      end
    end
    if (!found) begin
      total++;
      $display("FAIL timeout_wait: got no out_timeout, expected one within 5000 cycles");
    end
    check("timeout_cycle", to_at, at + TIMEOUT);
    wait_issue(a2, b);
    check("after_timeout_issue", a2, to_at + 2);
    check("timeout_count", n_tmo, tmo0 + 1);
    complete(1'b1);
    tick();

    // Reset mid-WAIT
    exp_q.push_back(8'h55);
    enq(8'h55, 0);
    wait_issue(at, b);
    tick();
    check("wait_before_reset", bus.out_busy, 1'b1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs("midwait_reset");
    tick();
    rst  = 1'b0;
    tmo0 = n_tmo;
    n0   = n_issue;
    repeat (TIMEOUT + 100) tick();
    check("reset_no_timeout", n_tmo, tmo0);
    check("reset_no_issue", n_issue, n0);

    // Simultaneous push and pop on a full queue
    bus.in_tx_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      enq(8'h80 + 8'(i), 2);
    end
    tick();
    d0 = n_drop;
    t  = cyc;
    exp_q.push_back(8'hC0);
    bus.in_desc_ID    = 8'hC0;
    bus.in_desc_queue = 2'd2;
    bus.in_desc_wr    = 1'b1;
    bus.in_tx_ready   = 1'b1;
    tick();
    bus.in_desc_wr    = 1'b0;
    wait_issue(at, b);
    check("pushpop_issue_cycle", at, t + 1);
    check("pushpop_no_drop", n_drop, d0);
    check("pushpop_q2_nonempty", bus.out_q_empty[2], 1'b0);
    complete(1'b1);
    for (int i = 0; i < 32; i++) begin
      wait_issue(at, b);
      complete(1'b1);
    end
    repeat (2) tick();
    check("final_empty", bus.out_q_empty, 4'hF);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_id_sched.md
# cache_id_sched

Read-side scheduler for `data_cache`.
- Holds per-queue FIFOs of packet IDs, each ID already allocated by `data_cache` and classified upstream.
- Selects the next ID by strict priority among non-empty queues whose TSN gate is open.
- Issues one ID at a time to `data_cache`, then waits for that packet's end-of-packet valid before issuing the next.
- Sits between the classifier/gate-control logic and `data_cache`'s `in_data_cache_ID` / `in_data_cache_ID_wr` inputs.

## Interface
Reset is synchronous and active-high; one clock.

Parameters:
- `NQ`, 4, number of priority queues; queue `NQ-1` has highest priority.
- `QDEPTH`, 32, ID FIFO depth per queue (power of two).
- `TIMEOUT`, 4096, maximum WAIT cycles before the scheduler abandons an issued ID.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_desc_ID` in 8: packet ID to enqueue.
- `in_desc_queue` in log2(NQ): target queue.
- `in_desc_wr` in 1: enqueue strobe.
- `in_gate` in NQ: per-queue gate; 1 = open.
- `in_tx_ready` in 1: downstream (ebm) can accept a whole packet.
- `out_sched_ID` out 8: ID to `data_cache`.
- `out_sched_ID_wr` out 1: one-cycle issue strobe.
- `in_cache_valid_wr` in 1: end-of-packet strobe from `data_cache`.
- `in_cache_valid` in 1: packet-good flag, sampled with `in_cache_valid_wr`.
- `out_q_empty` out NQ: per-queue empty flags.
- `out_drop` out 1: one-cycle pulse when an enqueue hits a full queue.
- `out_timeout` out 1: one-cycle pulse when WAIT expires.
- `out_busy` out 1: high while in WAIT.

## Operation
- **Enqueue:** on `in_desc_wr`, the ID is written to FIFO[`in_desc_queue`].
  - If that FIFO is full, the ID is discarded and `out_drop` pulses next cycle.
  - Other queues are unaffected.
- **FSM states:** IDLE, WAIT.
- **IDLE:**
  - The eligible set is queues that are non-empty, have their gate open, and only while `in_tx_ready`=1.
  - If the set is non-empty, select the highest-index eligible queue and pop its head.
  - Register the popped ID on `out_sched_ID`, assert `out_sched_ID_wr` for one cycle, clear the watchdog, and go to WAIT.
- **WAIT:**
  - On `in_cache_valid_wr`=1, go to IDLE. `in_cache_valid` has no effect on scheduling; good and bad packets both complete the issue.
  - Otherwise, if the watchdog reaches `TIMEOUT-1`, pulse `out_timeout` and go to IDLE.
  - The gate closing or `in_tx_ready` dropping during WAIT does not abort the packet.
- **Spurious end-of-packet:** `in_cache_valid_wr` while in IDLE is ignored.
- **Simultaneous enqueue and pop on the same queue:** both occur.
  - The count is unchanged.
  - A full queue still accepts the write when it is popped that same cycle.
- **Empty-queue enqueue:** an ID enqueued into an empty queue is not eligible in the same cycle it is written.
- **Pointer wrap-around:** FIFO pointers use log2(QDEPTH)+1 bits; full = MSB differs and low bits are equal.
- **Reset:**
  - Clears all FIFOs, returns the FSM to IDLE and clears the watchdog.
  - Outputs after reset: `out_sched_ID`=0, `out_sched_ID_wr`=0, `out_q_empty`=all 1, `out_drop`=0, `out_timeout`=0, `out_busy`=0.
  - Reset in mid-WAIT discards the outstanding issue; no pulse is generated for it.

## Timing
- **Enqueue-to-issue latency:** an enqueue in cycle t gives the earliest `out_sched_ID_wr` in cycle t+2.
  - t+1: IDLE sees the queue non-empty.
  - t+2: registered issue.
- **Issue-to-WAIT:** `out_busy` rises in the same cycle as `out_sched_ID_wr`.
- **Back-to-back:** `in_cache_valid_wr` in cycle c gives IDLE at c+1, the next `out_sched_ID_wr` no earlier than c+2, and `out_busy` low for at least c+1.
- **Issue rate:** at most one ID outstanding; IDs are never issued in consecutive cycles.
- **Timeout:** `out_timeout` fires `TIMEOUT` cycles after the issue cycle; IDLE follows on the next cycle.
- **Sampling:** `in_gate` and `in_tx_ready` are sampled only in IDLE, in the decision cycle.
- **Empty flags:** `out_q_empty` is registered and updates one cycle after the push or pop.

## Structure
- **Package `cache_sched_pkg`:** `ID_W`=8, default `NQ`/`QDEPTH`/`TIMEOUT`, and the state enum (IDLE, WAIT).
- **Sub-module `id_fifo`:** synchronous FIFO, ID_W wide and QDEPTH deep, with push/pop/full/empty. Instantiated NQ times.
- **Top level:** priority encoder, FSM and watchdog counter.

## Test plan
- **Basic issue:**
  - Stimulus: after reset, enqueue ID 0x05 to q0 with all gates open and `in_tx_ready`=1.
  - Response: `out_sched_ID`=0x05 with `_wr` high exactly 2 cycles later; `out_busy`=1 until 1 cycle after `in_cache_valid_wr`.
- **Priority and gating:**
  - Stimulus: enqueue 0x10→q0, 0x20→q3, 0x30→q2 with `in_gate`=4'b1011.
  - Response: issue order is 0x20, 0x10. Then open q2: 0x30 is issued.
- **Full queue:**
  - Stimulus: enqueue 33 IDs to q1 while `in_tx_ready`=0.
  - Response: `out_drop` pulses once, on the 33rd. Releasing `in_tx_ready` yields the first 32 IDs in order.
- **Timeout:**
  - Stimulus: issue ID 0x7F and never assert `in_cache_valid_wr`.
  - Response: `out_timeout` pulses 4096 cycles after the issue; the next queued ID is issued 2 cycles later.
- **Reset mid-WAIT and simultaneous push/pop:**
  - Stimulus: assert `rst` during WAIT.
  - Response: all outputs at their reset values next cycle and no `out_timeout`.
  - Stimulus: push to a full q2 in the same cycle q2 is popped.
  - Response: no drop, and `out_q_empty[2]`=0.
